// File: rtl/z80_uart_io.sv
// rtl/z80_uart_io.sv - I/O-mapped 8N1 UART with 4-entry TX FIFO for the Z80 bus
module z80_uart_io #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [7:0]  BASE_PORT    = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] address,
  input  logic [7:0] dbus_out,
  output logic [7:0] dbus_in,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       s_rx,
  output logic       s_tx
);

  localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  BIT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]     STAT_PORT = BASE_PORT + 8'd1;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------- bus decode ----------------
  logic hit_data, hit_stat, addr_hit, wr_act, rd_act;
  logic wr_act_q, rd_act_q, rd_stat_q;
  logic push, rd_end, data_rd_end, stat_rd_end;

  assign hit_data    = (address == BASE_PORT);
  assign hit_stat    = (address == STAT_PORT);
  assign addr_hit    = hit_data || hit_stat;
  assign wr_act      = !iorq_n && !wr_n && addr_hit;
  assign rd_act      = !iorq_n && !rd_n && addr_hit;
  assign rd_end      = rd_act_q && !rd_act;
  assign data_rd_end = rd_end && !rd_stat_q;
  assign stat_rd_end = rd_end && rd_stat_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_act_q  <= 1'b0;
      rd_act_q  <= 1'b0;
      rd_stat_q <= 1'b0;
    end else begin
      wr_act_q <= wr_act;
      rd_act_q <= rd_act;
      if (rd_act)
        rd_stat_q <= hit_stat;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0] fifo_mem [4];
  logic [1:0] fifo_wp, fifo_rp;
  logic [2:0] fifo_cnt;
  logic       fifo_empty, tx_full, tx_pop;

  assign fifo_empty = (fifo_cnt == 3'd0);
  assign tx_full    = (fifo_cnt == 3'd4);
  assign push       = wr_act && !wr_act_q && hit_data && !tx_full;

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[fifo_wp] <= dbus_out;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_wp  <= 2'd0;
      fifo_rp  <= 2'd0;
      fifo_cnt <= 3'd0;
    end else begin
      if (push)
        fifo_wp <= fifo_wp + 2'd1;
      if (tx_pop)
        fifo_rp <= fifo_rp + 2'd1;
      case ({push, tx_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------- TX shifter ----------------
  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shift;
  logic          tx_bit_end, tx_idle;

  assign tx_bit_end = (tx_cnt == BIT_LAST);
  assign tx_pop     = !fifo_empty &&
                      ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_bit_end));
  assign tx_idle    = fifo_empty && (tx_state == TX_IDLE);

  // s_tx is registered from the current state, so the line lags the state by one clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= 3'd0;
      tx_shift <= 8'h00;
      s_tx     <= 1'b1;
    end else begin
      case (tx_state)
        TX_START: s_tx <= 1'b0;
        TX_DATA:  s_tx <= tx_shift[tx_idx];
        default:  s_tx <= 1'b1;
      endcase
      case (tx_state)
        TX_IDLE: begin
          tx_cnt <= '0;
          if (tx_pop) begin
            tx_shift <= fifo_mem[fifo_rp];
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_cnt   <= '0;
            tx_idx   <= 3'd0;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            tx_idx <= tx_idx + 3'd1;
            if (tx_idx == 3'd7)
              tx_state <= TX_STOP;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_pop) begin
              tx_shift <= fifo_mem[fifo_rp];
              tx_state <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------- RX path ----------------
  logic          rx_s1, rx_s2, rx_s3, rx_fall;
  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift, rx_hold;
  logic          rx_valid, rx_overrun, frame_err, rx_bit_end;

  assign rx_fall    = rx_s3 && !rx_s2;
  assign rx_bit_end = (rx_cnt == BIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= s_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // Bus-side clears come first so that a completion in the same cycle overrides them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_idx     <= 3'd0;
      rx_shift   <= 8'h00;
      rx_hold    <= 8'h00;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (data_rd_end)
        rx_valid <= 1'b0;
      if (stat_rd_end) begin
        rx_overrun <= 1'b0;
        frame_err  <= 1'b0;
      end
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_fall)
            rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == BIT_HALF) begin
            rx_cnt <= '0;
            rx_idx <= 3'd0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_bit_end) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_idx   <= rx_idx + 3'd1;
            if (rx_idx == 3'd7)
              rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          if (rx_bit_end) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_s2) begin
              rx_hold  <= rx_shift;
              rx_valid <= 1'b1;
              if (rx_valid && !data_rd_end)
                rx_overrun <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------- read mux ----------------
  logic [7:0] status;
  assign status  = {3'b000, frame_err, rx_overrun, tx_idle, tx_full, rx_valid};
  assign dbus_in = rd_act ? (hit_stat ? status : rx_hold) : 8'hFF;

endmodule

// File: tb/tb_z80_uart_io.sv
// tb/tb_z80_uart_io.sv - self-checking bench for z80_uart_io with a byte-level reference model
module tb_z80_uart_io;

  localparam int         CPB   = 4;
  localparam logic [7:0] DPORT = 8'h10;
  localparam logic [7:0] SPORT = 8'h11;
  localparam int         LOGN  = 4096;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] address = 8'h00;
  logic [7:0] dbus_out = 8'h00;
  logic [7:0] dbus_in;
  logic       iorq_n = 1'b1;
  logic       rd_n = 1'b1;
  logic       wr_n = 1'b1;
  logic       s_rx = 1'b1;
  logic       s_tx;

  z80_uart_io #(.CLKS_PER_BIT(CPB), .BASE_PORT(DPORT)) dut (
    .clk(clk), .reset(reset), .address(address), .dbus_out(dbus_out),
    .dbus_in(dbus_in), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .s_rx(s_rx), .s_tx(s_tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // tx_log[k] holds s_tx as seen after rising edge number k
  logic tx_log [LOGN];
  always @(negedge clk) if (cyc < LOGN) tx_log[cyc] = s_tx;

  int checks = 0;
  int failures = 0;

  // Reference model of the CPU-visible receive state
  logic       m_valid = 1'b0, m_ov = 1'b0, m_fe = 1'b0;
  logic [7:0] m_hold = 8'h00;

  function automatic logic [7:0] exp_status(input logic idle, input logic full);
    return {3'b000, m_fe, m_ov, idle, full, m_valid};
  endfunction

  function automatic void model_rx(input logic [7:0] b, input logic stop);
    if (stop) begin
      if (m_valid) m_ov = 1'b1;
      m_hold  = b;
      m_valid = 1'b1;
    end else begin
      m_fe = 1'b1;
    end
  endfunction

  // Number of samples in a 10-bit frame starting at log index st that differ from the ideal waveform
  function automatic int frame_diffs(input int st, input logic [7:0] b);
    int n = 0;
    logic e;
    for (int i = 0; i < 10 * CPB; i++) begin
      if (i < CPB) e = 1'b0;
      else if (i < 9 * CPB) e = b[(i - CPB) / CPB];
      else e = 1'b1;
      if (st + i >= LOGN || tx_log[st + i] !== e) n++;
    end
    return n;
  endfunction

  task automatic io_write(input logic [7:0] a, input logic [7:0] d, output int edge_n);
    @(negedge clk);
    address = a; dbus_out = d; iorq_n = 1'b0; wr_n = 1'b0;
    edge_n = cyc + 1;
    repeat (2) @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic io_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    address = a; iorq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    d = dbus_in;
    @(negedge clk);
    iorq_n = 1'b1; rd_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      s_rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
    s_rx = 1'b1;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    repeat (3) @(negedge clk);
    checks++;
    if (s_tx !== 1'b1) begin failures++; $display("FAIL reset_s_tx got=%b exp=1", s_tx); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (dbus_in !== 8'hFF) begin failures++; $display("FAIL idle_dbus got=%h exp=ff", dbus_in); end
    io_read(SPORT, d);
    checks++;
    if (d !== exp_status(1'b1, 1'b0)) begin failures++; $display("FAIL reset_status got=%h exp=%h", d, exp_status(1'b1, 1'b0)); end
    io_read(DPORT, d);
    m_valid = 1'b0;
    checks++;
    if (d !== m_hold) begin failures++; $display("FAIL reset_hold got=%h exp=%h", d, m_hold); end
  endtask

  task automatic test_tx_single;
    logic [7:0] b, d;
    int n, nd;
    for (int k = 0; k < 3; k++) begin
      b = (k == 0) ? 8'hA5 : 8'($urandom);
      io_write(DPORT, b, n);
      io_read(SPORT, d);
      checks++;
      if (d !== exp_status(1'b0, 1'b0)) begin failures++; $display("FAIL tx_busy_status got=%h exp=%h", d, exp_status(1'b0, 1'b0)); end
      m_ov = 1'b0; m_fe = 1'b0;
      repeat (10 * CPB + 6) @(negedge clk);
      checks++;
      if (tx_log[n + 1] !== 1'b1) begin failures++; $display("FAIL tx_early_start got=%b exp=1", tx_log[n + 1]); end
      nd = frame_diffs(n + 2, b);
      checks++;
      if (nd != 0) begin failures++; $display("FAIL tx_frame byte=%h bad_samples=%0d exp=0", b, nd); end
      io_read(SPORT, d);
      checks++;
      if (d !== exp_status(1'b1, 1'b0)) begin failures++; $display("FAIL tx_done_status got=%h exp=%h", d, exp_status(1'b1, 1'b0)); end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_q [$];
    logic [7:0] d;
    int n0, nx, nd, hi;
    exp_q.push_back(8'($urandom));
    io_write(DPORT, exp_q[0], n0);
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(8'(k));
      io_write(DPORT, 8'(k), nx);
    end
    io_read(SPORT, d);
    checks++;
    if (d !== exp_status(1'b0, 1'b1)) begin failures++; $display("FAIL b2b_full got=%h exp=%h", d, exp_status(1'b0, 1'b1)); end
    io_write(DPORT, 8'h05, nx);
    repeat (5 * 10 * CPB + 20) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      nd = frame_diffs(n0 + 2 + k * 10 * CPB, exp_q[k]);
      checks++;
      if (nd != 0) begin failures++; $display("FAIL b2b_frame%0d byte=%h bad_samples=%0d exp=0", k, exp_q[k], nd); end
    end
    hi = 0;
    for (int i = 0; i < 15; i++) if (tx_log[n0 + 2 + 50 * CPB + i] === 1'b1) hi++;
    checks++;
    if (hi != 15) begin failures++; $display("FAIL b2b_dropped high_samples=%0d exp=15", hi); end
    io_read(SPORT, d);
    checks++;
    if (d !== exp_status(1'b1, 1'b0)) begin failures++; $display("FAIL b2b_idle got=%h exp=%h", d, exp_status(1'b1, 1'b0)); end
  endtask

  task automatic test_rx;
    logic [7:0] b, d;
    for (int k = 0; k < 5; k++) begin
      b = (k == 0) ? 8'h3C : 8'($urandom);
      rx_send(b, 1'b1);
      model_rx(b, 1'b1);
      repeat (2) @(negedge clk);
      io_read(DPORT, d);
      checks++;
      if (d !== m_hold) begin failures++; $display("FAIL rx_data got=%h exp=%h", d, m_hold); end
      m_valid = 1'b0;
      io_read(SPORT, d);
      checks++;
      if (d !== exp_status(1'b1, 1'b0)) begin failures++; $display("FAIL rx_status got=%h exp=%h", d, exp_status(1'b1, 1'b0)); end
      m_ov = 1'b0; m_fe = 1'b0;
    end
  endtask

  task automatic test_overrun;
    logic [7:0] a, b, d;
    for (int k = 0; k < 2; k++) begin
      a = (k == 0) ? 8'h11 : 8'($urandom);
      b = (k == 0) ? 8'h22 : 8'($urandom);
      rx_send(a, 1'b1); model_rx(a, 1'b1);
      rx_send(b, 1'b1); model_rx(b, 1'b1);
      repeat (3) @(negedge clk);
      io_read(DPORT, d);
      checks++;
      if (d !== m_hold) begin failures++; $display("FAIL ovr_data got=%h exp=%h", d, m_hold); end
      m_valid = 1'b0;
      io_read(SPORT, d);
      checks++;
      if (d !== exp_status(1'b1, 1'b0)) begin failures++; $display("FAIL ovr_status got=%h exp=%h", d, exp_status(1'b1, 1'b0)); end
      m_ov = 1'b0; m_fe = 1'b0;
      io_read(SPORT, d);
      checks++;
      if (d !== exp_status(1'b1, 1'b0)) begin failures++; $display("FAIL ovr_cleared got=%h exp=%h", d, exp_status(1'b1, 1'b0)); end
    end
  endtask

  task automatic test_frame_err;
    logic [7:0] b, d;
    b = 8'($urandom);
    rx_send(b, 1'b0);
    model_rx(b, 1'b0);
    repeat (4) @(negedge clk);
    io_read(SPORT, d);
    checks++;
    if (d !== exp_status(1'b1, 1'b0)) begin failures++; $display("FAIL ferr_status got=%h exp=%h", d, exp_status(1'b1, 1'b0)); end
    m_ov = 1'b0; m_fe = 1'b0;
    io_read(SPORT, d);
    checks++;
    if (d !== exp_status(1'b1, 1'b0)) begin failures++; $display("FAIL ferr_cleared got=%h exp=%h", d, exp_status(1'b1, 1'b0)); end
  endtask

  task automatic test_glitch;
    logic [7:0] b, d;
    @(negedge clk) s_rx = 1'b0;
    @(negedge clk) s_rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    io_read(SPORT, d);
    checks++;
    if (d !== exp_status(1'b1, 1'b0)) begin failures++; $display("FAIL glitch_status got=%h exp=%h", d, exp_status(1'b1, 1'b0)); end
    m_ov = 1'b0; m_fe = 1'b0;
    b = 8'($urandom);
    rx_send(b, 1'b1);
    model_rx(b, 1'b1);
    repeat (2) @(negedge clk);
    io_read(DPORT, d);
    checks++;
    if (d !== m_hold) begin failures++; $display("FAIL glitch_recover got=%h exp=%h", d, m_hold); end
    m_valid = 1'b0;
  endtask

  task automatic test_reset_mid_tx;
    logic [7:0] d;
    logic found;
    int n, r0, hi;
    io_write(DPORT, 8'($urandom) & 8'hFE, n);
    io_write(DPORT, 8'($urandom), n);
    found = 1'b0;
    for (int i = 0; i < 10 * CPB && !found; i++) begin
      @(negedge clk);
      if (s_tx === 1'b0) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL midtx_low_timeout got=%b exp=0", s_tx); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (s_tx !== 1'b1) begin failures++; $display("FAIL midtx_async got=%b exp=1", s_tx); end
    @(negedge clk) reset = 1'b0;
    m_valid = 1'b0; m_ov = 1'b0; m_fe = 1'b0; m_hold = 8'h00;
    r0 = cyc;
    repeat (12 * CPB) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 12 * CPB; i++) if (tx_log[r0 + i] === 1'b1) hi++;
    checks++;
    if (hi != 12 * CPB) begin failures++; $display("FAIL midtx_fifo_lost high_samples=%0d exp=%0d", hi, 12 * CPB); end
    io_read(SPORT, d);
    checks++;
    if (d !== exp_status(1'b1, 1'b0)) begin failures++; $display("FAIL midtx_status got=%h exp=%h", d, exp_status(1'b1, 1'b0)); end
    io_read(DPORT, d);
    checks++;
    if (d !== m_hold) begin failures++; $display("FAIL midtx_hold got=%h exp=%h", d, m_hold); end
  endtask

  initial begin
    test_reset;
    test_tx_single;
    test_back_to_back;
    test_rx;
    test_overrun;
    test_frame_err;
    test_glitch;
    test_reset_mid_tx;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
